// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Flow is IDLE (grant) -> EXEC (ALU evaluates) -> RESP (hold response until accepted).
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic [2:0]        req0_op_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  input  logic [2:0]        req1_op_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [2:0]        alu_op_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_carry_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_carry_o,
  output logic              rsp_zero_o,
  output logic              rsp_err_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q;
  logic              ptr_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [2:0]        alu_op_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_carry_q;
  logic              rsp_zero_q;
  logic              rsp_err_q;

  logic              gnt_vld;
  logic              gnt_id;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [2:0]        sel_op;
  logic              illegal_op;
  logic [DATA_W-1:0] rsp_result_d;
  logic              rsp_carry_d;
  logic              rsp_zero_d;

  // ptr_q holds the last requester served; a tie goes to the other one.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (state_q == IDLE && !rst_i) begin
      if (req0_valid_i && req1_valid_i) begin
        gnt_vld = 1'b1;
        gnt_id  = ~ptr_q;
      end else if (req0_valid_i) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1_valid_i) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign req0_ready_o = gnt_vld && !gnt_id;
  assign req1_ready_o = gnt_vld && gnt_id;

  assign sel_a  = gnt_id ? req1_a_i  : req0_a_i;
  assign sel_b  = gnt_id ? req1_b_i  : req0_b_i;
  assign sel_op = gnt_id ? req1_op_i : req0_op_i;

  assign illegal_op   = (alu_op_q == 3'd3) || (alu_op_q == 3'd4) || (alu_op_q == 3'd5);
  assign rsp_result_d = illegal_op ? '0 : alu_result_i;
  // The ALU carry is only meaningful for ADD and SUB; otherwise it is stale.
  assign rsp_carry_d  = ((alu_op_q == 3'd2) || (alu_op_q == 3'd6)) && alu_carry_i;
  assign rsp_zero_d   = (rsp_result_d == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 3'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            alu_a_q  <= sel_a;
            alu_b_q  <= sel_b;
            alu_op_q <= sel_op;
            rsp_id_q <= gnt_id;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= rsp_result_d;
          rsp_carry_q  <= rsp_carry_d;
          rsp_zero_q   <= rsp_zero_d;
          rsp_err_q    <= illegal_op;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            ptr_q       <= rsp_id_q;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_op_o     = alu_op_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_carry_o  = rsp_carry_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp_err_o    = rsp_err_q;

endmodule
